// File: rtl/counter_step_pkg.sv
// Shared types and default sizes for the counter step driver.
package counter_step_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/step_clip.sv
// Remaining-distance and clipped step size for the next up/dn command.
module step_clip #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] shadow_q,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  output logic             dir_up,
  output logic             dist_zero,
  output logic [WIDTH-1:0] clipped_b
);

  logic [WIDTH-1:0] w_dist;

  // Distance is taken in the direction of travel, so it never wraps.
  assign dir_up    = (target > shadow_q);
  assign w_dist    = dir_up ? (target - shadow_q) : (shadow_q - target);
  assign dist_zero = (w_dist == '0);
  assign clipped_b = (step < w_dist) ? step : w_dist;

endmodule

// File: rtl/counter_step_driver.sv
// Drives load/up/dn/b of a saturating counter until it reaches a target.
// Optional COUNTER_STEP_DRV_PAUSE_EN adds a pause input that freezes STEP.
module counter_step_driver
  import counter_step_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
`ifdef COUNTER_STEP_DRV_PAUSE_EN
  input  logic             pause,
`endif
  output logic             ctr_load,
  output logic [WIDTH-1:0] ctr_a,
  output logic [WIDTH-1:0] ctr_b,
  output logic             ctr_up,
  output logic             ctr_dn,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] n_steps
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_start_val;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_shadow;
  logic [CNT_W-1:0] r_n_steps;
  logic             r_abort;

  logic             w_dir_up;
  logic             w_dist_zero;
  logic [WIDTH-1:0] w_clip_b;
  logic             w_hold;
  logic             w_cmd;

  step_clip #(.WIDTH(WIDTH)) u_clip (
    .shadow_q  (r_shadow),
    .target    (r_target),
    .step      (r_step),
    .dir_up    (w_dir_up),
    .dist_zero (w_dist_zero),
    .clipped_b (w_clip_b)
  );

`ifdef COUNTER_STEP_DRV_PAUSE_EN
  logic r_pause;

  // Pause is registered so every output stays a function of state alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pause <= 1'b0;
    else     r_pause <= pause;
  end

  assign w_hold = r_pause;
`else
  assign w_hold = 1'b0;
`endif

  assign w_cmd = (r_state == STEP) && !w_hold && !w_dist_zero && (r_step != '0);

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: w_next = STEP;
      STEP: if (!w_hold && (w_dist_zero || (r_step == '0))) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ctr_load = (r_state == LOAD);
    ctr_a    = (r_state == LOAD) ? r_start_val : '0;
    ctr_up   = w_cmd &&  w_dir_up;
    ctr_dn   = w_cmd && !w_dir_up;
    ctr_b    = w_cmd ? w_clip_b : '0;
    shadow_q = r_shadow;
    busy     = (r_state == LOAD) || (r_state == STEP);
    done     = (r_state == DONE);
    err      = (r_state == DONE) && r_abort;
    n_steps  = r_n_steps;
  end

  // NOTE: state uses non-blocking assignments and an async reset, so commands drop the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_start_val <= '0;
      r_target    <= '0;
      r_step      <= '0;
      r_shadow    <= '0;
      r_n_steps   <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_start_val <= start_val;
            r_target    <= target;
            r_step      <= step;
            r_n_steps   <= '0;
            r_abort     <= 1'b0;
          end
        end
        LOAD: r_shadow <= r_start_val;
        STEP: begin
          if (w_cmd) begin
            r_shadow  <= w_dir_up ? (r_shadow + w_clip_b) : (r_shadow - w_clip_b);
            r_n_steps <= (&r_n_steps) ? r_n_steps : r_n_steps + 1'b1;
          end else if (!w_hold && !w_dist_zero) begin
            r_abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_step_driver.sv
// Directed bench: the driver beside a saturating up/down counter model.
module tb_counter_step_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_val;
  logic [7:0] target;
  logic [7:0] step;
`ifdef COUNTER_STEP_DRV_PAUSE_EN
  logic       pause;
`endif
  logic       ctr_load;
  logic [7:0] ctr_a;
  logic [7:0] ctr_b;
  logic       ctr_up;
  logic       ctr_dn;
  logic [7:0] shadow_q;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] n_steps;
  logic [7:0] q;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  counter_step_driver #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .target    (target),
    .step      (step),
`ifdef COUNTER_STEP_DRV_PAUSE_EN
    .pause     (pause),
`endif
    .ctr_load  (ctr_load),
    .ctr_a     (ctr_a),
    .ctr_b     (ctr_b),
    .ctr_up    (ctr_up),
    .ctr_dn    (ctr_dn),
    .shadow_q  (shadow_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .n_steps   (n_steps)
  );

  // Saturating counter: load wins; up/dn steps that would overflow are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          q <= 8'd0;
    else if (ctr_load)                                q <= ctr_a;
    else if (ctr_up && ({1'b0, q} + {1'b0, ctr_b} <= 9'd255)) q <= q + ctr_b;
    else if (ctr_dn && (q >= ctr_b))                  q <= q - ctr_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("q_mirror", {24'd0, q}, {24'd0, shadow_q});
      check("up_dn_excl", {31'd0, ctr_up & ctr_dn}, 32'd0);
      if (!ctr_up && !ctr_dn) check("b_idle", {24'd0, ctr_b}, 32'd0);
    end
  end

  // One move; exp_bs packs the expected b values, first command in the low byte.
  task automatic move(input string name, input logic [7:0] sv, input logic [7:0] tg,
                      input logic [7:0] st, input logic exp_up, input int exp_cnt,
                      input logic [31:0] exp_bs, input int exp_lat, input logic exp_err,
                      input logic [7:0] exp_q, input int pause_at, input int pause_len,
                      input logic inj);
    logic [7:0] obs [4];
    int         cnt;
    int         lat;
    logic       got_err;
    logic [7:0] n_at_done;
    cnt = 0;
    lat = -1;
    got_err = 1'b0;
    n_at_done = 8'd0;
    for (int i = 0; i < 4; i++) obs[i] = 8'd0;
    @(negedge clk);
    start = 1'b1; start_val = sv; target = tg; step = st;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check({name, "_load"}, {31'd0, ctr_load}, 32'd1);
        check({name, "_ctr_a"}, {24'd0, ctr_a}, {24'd0, sv});
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
      end
      if (ctr_up || ctr_dn) begin
        check({name, "_dir"}, {31'd0, ctr_up}, {31'd0, exp_up});
        if (cnt < 4) obs[cnt] = ctr_b;
        cnt++;
      end
      if (done) begin
        lat = c;
        got_err = err;
        n_at_done = n_steps;
      end
      if (inj && c == 3) begin
        start = 1'b1; start_val = 8'd0; target = 8'd0; step = 8'd1;
      end
      if (inj && c == 4) start = 1'b0;
`ifdef COUNTER_STEP_DRV_PAUSE_EN
      pause = (pause_len > 0) && (c >= pause_at) && (c < pause_at + pause_len);
`endif
    end
`ifdef COUNTER_STEP_DRV_PAUSE_EN
    pause = 1'b0;
`endif
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    check({name, "_cmds"}, cnt, exp_cnt);
    for (int i = 0; i < exp_cnt && i < 4; i++)
      check({name, "_b"}, {24'd0, obs[i]}, {24'd0, exp_bs[8*i +: 8]});
    check({name, "_q"}, {24'd0, q}, {24'd0, exp_q});
    check({name, "_n_steps"}, {24'd0, n_at_done}, exp_cnt);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_n_hold"}, {24'd0, n_steps}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_val = 8'd0; target = 8'd0; step = 8'd0;
`ifdef COUNTER_STEP_DRV_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_shadow", {24'd0, shadow_q}, 32'd0);
    check("rst_load", {31'd0, ctr_load}, 32'd0);
    check("rst_done", {31'd0, done | err}, 32'd0);
    rst = 1'b0;

    move("up3",   8'd10,  8'd50,  8'd15,  1'b1, 3, 32'h000A0F0F, 6, 1'b0, 8'd50,  0, 0, 1'b0);
    move("dn2",   8'd200, 8'd3,   8'd100, 1'b0, 2, 32'h00006164, 5, 1'b0, 8'd3,   0, 0, 1'b0);
    move("top",   8'd250, 8'd255, 8'd20,  1'b1, 1, 32'h00000005, 4, 1'b0, 8'd255, 0, 0, 1'b0);
    move("zero",  8'd5,   8'd0,   8'd2,   1'b0, 3, 32'h00010202, 6, 1'b0, 8'd0,   0, 0, 1'b0);
    move("same",  8'd7,   8'd7,   8'd4,   1'b0, 0, 32'h0,        3, 1'b0, 8'd7,   0, 0, 1'b0);
    move("abort", 8'd0,   8'd9,   8'd0,   1'b0, 0, 32'h0,        3, 1'b1, 8'd0,   0, 0, 1'b0);

    // Async reset after the first step of a move.
    @(negedge clk);
    start = 1'b1; start_val = 8'd10; target = 8'd50; step = 8'd15;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_cmd", {31'd0, ctr_up}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cmd", {30'd0, ctr_up, ctr_dn}, 32'd0);
    check("mid_rst_b", {24'd0, ctr_b}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_shadow", {24'd0, shadow_q}, 32'd0);
    check("mid_rst_n", {24'd0, n_steps}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start pulsed during STEP must not disturb the running move.
    move("inj", 8'd10, 8'd50, 8'd15, 1'b1, 3, 32'h000A0F0F, 6, 1'b0, 8'd50, 0, 0, 1'b1);
`ifdef COUNTER_STEP_DRV_PAUSE_EN
    move("pause", 8'd10, 8'd50, 8'd15, 1'b1, 3, 32'h000A0F0F, 10, 1'b0, 8'd50, 2, 4, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
